// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad responder: presses handshaked key codes for a fixed hold, then releases for a fixed gap.
// Define KEYPAD_BOUNCE_EN to add contact-bounce bursts around each hold.
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 64,
  parameter int GAP_CYCLES    = 32,
  parameter int BOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] KEY_C,
  output logic [3:0] KEY_R,
  output logic       busy,
  output logic [7:0] press_count
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
    $error("keypad_emulator: HOLD_CYCLES out of range");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 65535) begin : g_bad_gap
    $error("keypad_emulator: GAP_CYCLES out of range");
  end
  if (BOUNCE_CYCLES < 1 || BOUNCE_CYCLES > 255) begin : g_bad_bounce
    $error("keypad_emulator: BOUNCE_CYCLES out of range");
  end

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    GAP
`ifdef KEYPAD_BOUNCE_EN
    , BOUNCE_IN,
    BOUNCE_OUT
`endif
  } state_t;

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [3:0]  held;
  logic        count_inc;
  logic        contact;

`ifdef KEYPAD_BOUNCE_EN
  localparam logic [15:0] BOUNCE_LOAD = 16'(BOUNCE_CYCLES - 1);
  logic [15:0] bounce_elapsed;
  assign bounce_elapsed = BOUNCE_LOAD - cnt;
`endif

  function automatic logic [3:0] col_of(input logic [3:0] code);
    case (code)
      4'h0, 4'h2, 4'h5, 4'h8: col_of = 4'b1011;
      4'h1, 4'h4, 4'h7, 4'hE: col_of = 4'b0111;
      4'h3, 4'h6, 4'h9, 4'hF: col_of = 4'b1101;
      default:                col_of = 4'b1110;
    endcase
  endfunction

  function automatic logic [3:0] row_of(input logic [3:0] code);
    case (code)
      4'h1, 4'h2, 4'h3, 4'hA: row_of = 4'b0111;
      4'h4, 4'h5, 4'h6, 4'hB: row_of = 4'b1011;
      4'h7, 4'h8, 4'h9, 4'hC: row_of = 4'b1101;
      default:                row_of = 4'b1110;
    endcase
  endfunction

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      cnt         <= '0;
      held        <= '0;
      press_count <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (key_valid && key_ready)
        held <= key_code;
      if (count_inc)
        press_count <= press_count + 8'd1;
    end
  end

  // Each timed state counts down from its load value and leaves on the cycle the counter reads zero.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    count_inc  = 1'b0;
    contact    = 1'b0;
    case (state)
      IDLE: begin
        if (key_valid) begin
`ifdef KEYPAD_BOUNCE_EN
          state_next = BOUNCE_IN;
          cnt_next   = BOUNCE_LOAD;
`else
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
`endif
        end
      end
      HOLD: begin
        contact = 1'b1;
        if (cnt == 16'd0) begin
`ifdef KEYPAD_BOUNCE_EN
          state_next = BOUNCE_OUT;
          cnt_next   = BOUNCE_LOAD;
`else
          state_next = GAP;
          cnt_next   = GAP_LOAD;
          count_inc  = 1'b1;
`endif
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      GAP: begin
        if (cnt == 16'd0)
          state_next = IDLE;
        else
          cnt_next = cnt - 16'd1;
      end
`ifdef KEYPAD_BOUNCE_EN
      BOUNCE_IN: begin
        contact = ~bounce_elapsed[0];
        if (cnt == 16'd0) begin
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      BOUNCE_OUT: begin
        contact = bounce_elapsed[0];
        if (cnt == 16'd0) begin
          state_next = GAP;
          cnt_next   = GAP_LOAD;
          count_inc  = 1'b1;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign key_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Pure combinational path from KEY_C, like a real switch matrix.
  assign KEY_R = (contact && (KEY_C == col_of(held))) ? row_of(held) : 4'b1111;

endmodule
